fc8_vram_arbiter: RTL and testbench

Shares the single-port synchronous VRAM between the video scanout fetcher and the CPU's VRAM window (logical $8000–$FFFF when the page select register selects the VRAM bank). Video normally has priority. A wait counter bounds CPU starvation. The CPU side uses a four-phase req/ready handshake so `fc8_top` can stall the CPU during contention. Located in `fc8_top` between the CPU bus decode, the video fetch unit and the VRAM macro.

---
 rtl/fc8_vram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_fc8_vram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc8_vram_arbiter.sv
// VRAM arbiter: shares the single-port VRAM between video scanout fetches and the CPU window.
// Video has priority; a saturating wait counter forces a CPU win after CPU_MAX_WAIT lost rounds.
module fc8_vram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              clk_20mhz,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_data,
    output logic              vid_valid,
    output logic              vram_en,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata
);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_DATA   = 2'd1;
    localparam logic [1:0] C_DONE   = 2'd2;
    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    logic [1:0]        cpu_state_q, cpu_state_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              cpu_elig_s, cpu_win_s, vid_win_s;

    logic              vram_en_q, vram_en_d;
    logic              vram_we_q, vram_we_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]        vram_wdata_q, vram_wdata_d;
    logic              own1_q, own1_d;
    logic              tag2_vld_q, tag2_vld_d;
    logic              tag2_own_q, tag2_own_d;

    logic              cpu_ready_q, cpu_ready_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic              vid_valid_q, vid_valid_d;
    logic [7:0]        vid_data_q, vid_data_d;

    // One grant per cycle: a starved CPU beats video, otherwise video beats the CPU.
    always_comb begin
        cpu_elig_s = (cpu_state_q == C_IDLE) && cpu_req;
        cpu_win_s  = 1'b0;
        vid_win_s  = 1'b0;
        if (cpu_elig_s && (wait_cnt_q >= MAX_WAIT)) begin
            cpu_win_s = 1'b1;
        end else if (vid_req) begin
            vid_win_s = 1'b1;
        end else if (cpu_elig_s) begin
            cpu_win_s = 1'b1;
        end else begin
            cpu_win_s = 1'b0;
        end
    end

    // Starvation counter and CPU handshake FSM; C_DONE blocks re-issue until cpu_req drops.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        cpu_state_d = cpu_state_q;
        lat_cnt_d   = lat_cnt_q;
        if ((cpu_state_q != C_IDLE) || cpu_win_s) begin
            wait_cnt_d = 4'd0;
        end else if (cpu_elig_s && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
        case (cpu_state_q)
            C_IDLE: begin
                if (cpu_win_s) begin
                    cpu_state_d = C_DATA;
                    lat_cnt_d   = 2'd0;
                end else begin
                    cpu_state_d = C_IDLE;
                end
            end
            C_DATA: begin
                if (lat_cnt_q == 2'd2) begin
                    cpu_state_d = C_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            C_DONE: begin
                if (!cpu_req) begin
                    cpu_state_d = C_IDLE;
                end else begin
                    cpu_state_d = C_DONE;
                end
            end
            default: begin
                cpu_state_d = C_IDLE;
                lat_cnt_d   = 2'd0;
            end
        endcase
    end

    // Issue stage plus owner tag pipe; returned bytes are steered by the tag two cycles later.
    always_comb begin
        vram_en_d    = cpu_win_s | vid_win_s;
        vram_we_d    = cpu_win_s & cpu_we;
        own1_d       = cpu_win_s;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        if (cpu_win_s) begin
            vram_addr_d  = cpu_addr;
            vram_wdata_d = cpu_wdata;
        end else if (vid_win_s) begin
            vram_addr_d  = vid_addr;
        end else begin
            vram_addr_d  = vram_addr_q;
        end
        tag2_vld_d  = vram_en_q;
        tag2_own_d  = own1_q;
        cpu_ready_d = tag2_vld_q & tag2_own_q;
        vid_valid_d = tag2_vld_q & ~tag2_own_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_data_d  = vid_data_q;
        if (cpu_ready_d) begin
            cpu_rdata_d = vram_rdata;
        end else if (vid_valid_d) begin
            vid_data_d  = vram_rdata;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
    end

    // State and pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk_20mhz or negedge rst_n) begin
        if (!rst_n) begin
            cpu_state_q  <= C_IDLE;
            lat_cnt_q    <= 2'd0;
            wait_cnt_q   <= 4'd0;
            vram_en_q    <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= 8'd0;
            own1_q       <= 1'b0;
            tag2_vld_q   <= 1'b0;
            tag2_own_q   <= 1'b0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= 8'd0;
            vid_valid_q  <= 1'b0;
            vid_data_q   <= 8'd0;
        end else begin
            cpu_state_q  <= cpu_state_d;
            lat_cnt_q    <= lat_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            vram_en_q    <= vram_en_d;
            vram_we_q    <= vram_we_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            own1_q       <= own1_d;
            tag2_vld_q   <= tag2_vld_d;
            tag2_own_q   <= tag2_own_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_valid_q  <= vid_valid_d;
            vid_data_q   <= vid_data_d;
        end
    end

    assign vid_ack    = vid_win_s;
    assign vram_en    = vram_en_q;
    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_valid  = vid_valid_q;
    assign vid_data   = vid_data_q;

endmodule

// File: tb/tb_fc8_vram_arbiter.sv
// Bench for fc8_vram_arbiter: VRAM model, vector table, and scoreboard queues for both requesters.
module tb_fc8_vram_arbiter;

    localparam int AW = 15;

    logic          clk_20mhz = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, vid_req;
    logic [AW-1:0] cpu_addr, vid_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata, vid_data, vram_wdata;
    logic          cpu_ready, vid_ack, vid_valid, vram_en, vram_we;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_rdata = 8'h00;

    fc8_vram_arbiter #(.ADDR_W(AW), .CPU_MAX_WAIT(8)) dut (
        .clk_20mhz (clk_20mhz), .rst_n (rst_n),
        .cpu_req   (cpu_req),   .cpu_we (cpu_we), .cpu_addr (cpu_addr),
        .cpu_wdata (cpu_wdata), .cpu_rdata (cpu_rdata), .cpu_ready (cpu_ready),
        .vid_req   (vid_req),   .vid_addr (vid_addr), .vid_ack (vid_ack),
        .vid_data  (vid_data),  .vid_valid (vid_valid),
        .vram_en   (vram_en),   .vram_we (vram_we), .vram_addr (vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata (vram_rdata)
    );

    always #25 clk_20mhz = ~clk_20mhz;

    typedef struct {
        logic          is_cpu;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    exp_data;
        int            exp_lat;
    } vec_t;
    typedef struct { logic we; logic [7:0] data; } cpu_exp_t;
    typedef struct { logic [7:0] data; int due; } vid_exp_t;

    cpu_exp_t   cpu_q[$];
    vid_exp_t   vid_q[$];
    cpu_exp_t   mon_ce;
    vid_exp_t   mon_ve;
    logic [7:0] vram    [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic       ack_log [0:31];
    logic       vchk_pend = 1'b0;
    logic [AW-1:0] vchk_addr = '0;
    vec_t       vecs [8];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [43:0] outs_s;

    assign outs_s = {cpu_rdata, cpu_ready, vid_ack, vid_data, vid_valid,
                     vram_en, vram_we, vram_addr, vram_wdata};

    always @(posedge clk_20mhz) cyc <= cyc + 1;

    // Single-port synchronous VRAM macro model: read data appears the cycle after vram_en.
    always @(posedge clk_20mhz) begin
        if (vram_en) begin
            if (vram_we) vram[vram_addr] <= vram_wdata;
            vram_rdata <= vram[vram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: video issue check one cycle after vid_ack, scoreboard pops on each strobe.
    always @(negedge clk_20mhz) begin
        if (rst_n) begin
            if (vchk_pend) check("vid_issue", 64'({vram_en, vram_we, vram_addr}), 64'({1'b1, 1'b0, vchk_addr}));
            vchk_pend <= vid_ack;
            vchk_addr <= vid_addr;
            if (vid_valid) begin
                if (vid_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL vid_spurious: got vid_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_ve = vid_q.pop_front();
                    check("vid_data", 64'(vid_data), 64'(mon_ve.data));
                    check("vid_valid_cycle", 64'(cyc), 64'(mon_ve.due));
                end
            end
            if (cpu_ready) begin
                if (cpu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_spurious: got cpu_ready=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_ce = cpu_q.pop_front();
                    if (!mon_ce.we) check("cpu_rdata", 64'(cpu_rdata), 64'(mon_ce.data));
                end
            end
        end else begin
            vchk_pend <= 1'b0;
        end
    end

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                              input logic [7:0] exp, input int exp_lat, input int hold);
        int       n;
        bit       got;
        cpu_exp_t ce;
        @(posedge clk_20mhz); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        ce.we = we; ce.data = exp;
        cpu_q.push_back(ce);
        if (we) ref_mem[addr] = wdata;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk_20mhz);
            if (n == exp_lat - 2) begin
                if (we) check("cpu_issue_wr", 64'({vram_en, vram_we, vram_addr, vram_wdata}),
                              64'({1'b1, 1'b1, addr, wdata}));
                else    check("cpu_issue_rd", 64'({vram_en, vram_we, vram_addr}), 64'({1'b1, 1'b0, addr}));
            end
            if (cpu_ready) got = 1'b1;
            else n++;
        end
        check("cpu_latency", 64'(n), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_20mhz);
            check("cpu_no_reissue", 64'(vram_en), 64'd0);
        end
        @(posedge clk_20mhz); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic vid_burst(input logic [AW-1:0] base, input int n_acks, input int max_cyc,
                             input bit use_exp, input logic [7:0] exp);
        int       k;
        int       acks;
        vid_exp_t ve;
        k = 0; acks = 0;
        while (acks < n_acks && k < max_cyc && k < 32) begin
            @(posedge clk_20mhz); #1;
            vid_req  = 1'b1;
            vid_addr = base + AW'(acks);
            @(negedge clk_20mhz);
            ack_log[k] = vid_ack;
            if (vid_ack) begin
                ve.data = use_exp ? exp : ref_mem[vid_addr];
                ve.due  = cyc + 3;
                vid_q.push_back(ve);
                acks++;
            end
            k++;
        end
        @(posedge clk_20mhz); #1;
        vid_req = 1'b0;
        check("vid_ack_count", 64'(acks), 64'(n_acks));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int       n;
        bit       got;
        cpu_exp_t ce;
        for (int i = 0; i < (1 << AW); i++) begin
            vram[i]    <= 8'h00;
            ref_mem[i] = 8'h00;
        end
        vram[15'h0010] <= 8'h11; ref_mem[15'h0010] = 8'h11;
        vram[15'h0011] <= 8'h22; ref_mem[15'h0011] = 8'h22;
        vram[15'h0012] <= 8'h33; ref_mem[15'h0012] = 8'h33;
        vram[15'h0013] <= 8'h44; ref_mem[15'h0013] = 8'h44;
        vram[15'h0100] <= 8'hAA; ref_mem[15'h0100] = 8'hAA;
        vram[15'h0101] <= 8'h55; ref_mem[15'h0101] = 8'h55;

        vecs[0] = '{1'b1, 1'b1, 15'h0000, 8'h0F, 8'h00, 3};
        vecs[1] = '{1'b1, 1'b0, 15'h0000, 8'h00, 8'h0F, 3};
        vecs[2] = '{1'b1, 1'b1, 15'h7FFF, 8'hA5, 8'h00, 3};
        vecs[3] = '{1'b1, 1'b0, 15'h7FFF, 8'h00, 8'hA5, 3};
        vecs[4] = '{1'b0, 1'b0, 15'h0010, 8'h00, 8'h11, 0};
        vecs[5] = '{1'b0, 1'b0, 15'h7FFF, 8'h00, 8'hA5, 0};
        vecs[6] = '{1'b1, 1'b0, 15'h0100, 8'h00, 8'hAA, 3};
        vecs[7] = '{1'b0, 1'b0, 15'h0101, 8'h00, 8'h55, 0};

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
        vid_req = 1'b0; vid_addr = '0;
        repeat (3) @(posedge clk_20mhz);
        @(negedge clk_20mhz);
        check("reset_outputs", 64'(outs_s), 64'd0);
        @(posedge clk_20mhz); #1;
        rst_n = 1'b1;
        @(negedge clk_20mhz);
        check("idle_outputs", 64'(outs_s), 64'd0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].is_cpu) cpu_access(vecs[v].we, vecs[v].addr, vecs[v].wdata,
                                           vecs[v].exp_data, vecs[v].exp_lat, 0);
            else vid_burst(vecs[v].addr, 1, 4, 1'b1, vecs[v].exp_data);
        end

        // Video streaming, one accepted fetch per cycle.
        vid_burst(15'h0010, 4, 8, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) check("stream_ack", 64'(ack_log[k]), 64'd1);

        // Request held after cpu_ready must not start a second access.
        cpu_access(1'b0, 15'h0000, 8'h00, 8'h0F, 3, 5);

        // Continuous video with a CPU request: CPU forced in after 8 lost rounds.
        fork
            vid_burst(15'h0010, 12, 20, 1'b0, 8'h00);
            cpu_access(1'b0, 15'h0100, 8'h00, 8'hAA, 11, 0);
        join
        for (int k = 0; k < 10; k++) check("starve_ack", 64'(ack_log[k]), (k == 8) ? 64'd0 : 64'd1);

        // CPU then video in adjacent cycles; each byte must land on its own strobe.
        fork
            cpu_access(1'b0, 15'h0100, 8'h00, 8'hAA, 3, 0);
            begin
                @(posedge clk_20mhz);
                vid_burst(15'h0101, 1, 4, 1'b0, 8'h00);
            end
        join
        // Simultaneous first-cycle requests: video first, CPU one cycle later.
        fork
            cpu_access(1'b0, 15'h0100, 8'h00, 8'hAA, 4, 0);
            vid_burst(15'h0101, 1, 4, 1'b0, 8'h00);
        join

        // Reset the cycle after a CPU grant, request held throughout.
        @(posedge clk_20mhz); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
        @(posedge clk_20mhz); #1;
        check("rst_pre_issue", 64'(vram_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 64'(outs_s), 64'd0);
        repeat (3) @(posedge clk_20mhz);
        #1;
        ce.we = 1'b0; ce.data = 8'hAA;
        cpu_q.push_back(ce);
        rst_n = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk_20mhz);
            if (cpu_ready) got = 1'b1;
            else n++;
        end
        check("rst_fresh_latency", 64'(n), 64'd3);
        @(posedge clk_20mhz); #1;
        cpu_req = 1'b0;

        repeat (8) @(posedge clk_20mhz);
        @(negedge clk_20mhz);
        check("vid_q_drained", 64'(vid_q.size()), 64'd0);
        check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
